// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg
//   UART transmitter with a TX FIFO, a configurable data-bit count (5..8),
//   optional odd/even parity and 1 or 2 stop bits. Queued frames go out
//   back-to-back. The next frame's START follows the last stop bit directly.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   data_in        payload to enqueue (DATA_BITS wide)
//   write_strobe   enqueue data_in this cycle
//   fifo_full      FIFO holds FIFO_DEPTH entries (registered)
//   fifo_empty     FIFO holds 0 entries (registered)
//   overflow_flag  sticky: a write was dropped while full; cleared by reset only
//   busy_flag      frame in progress or FIFO not empty (registered)
//   tx_done        one-cycle pulse aligned with the last cycle of the last stop bit
//   data_out       serial line, idle high, flop output
module uart_tx_fifo_cfg #(
    parameter int CLOCK_SPEED = 20_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 write_strobe,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 overflow_flag,
    output logic                 busy_flag,
    output logic                 tx_done,
    output logic                 data_out
);

    localparam int CYCLES_PER_BIT = CLOCK_SPEED / BAUD_RATE;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;

    // Illegal parity modes fall back to "no parity".
    localparam logic PARITY_EN  = (PARITY_MODE == 1) || (PARITY_MODE == 2);
    localparam logic PARITY_ODD = (PARITY_MODE == 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BIT - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    if (CYCLES_PER_BIT < 2) begin : g_chk_baud
        $error("uart_tx_fifo_cfg: CLOCK_SPEED/BAUD_RATE must be >= 2");
    end
    if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_chk_data
        $error("uart_tx_fifo_cfg: DATA_BITS must be in 5..8");
    end
    if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_chk_stop
        $error("uart_tx_fifo_cfg: STOP_BITS must be 1 or 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_chk_depth
        $error("uart_tx_fifo_cfg: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state, state_n;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_n;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_acc;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [2:0]           bit_cnt;

    logic bit_end;
    logic pop;
    logic wr_ok;
    logic line_n;
    logic done_n;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // A write while full still lands when the same cycle pops the head.
    assign wr_ok = write_strobe && (!fifo_full || pop);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        line_n  = 1'b1;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                line_n = 1'b0;
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                line_n = shreg[0];
                if (bit_end && (bit_cnt == DATA_LAST)) begin
                    state_n = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                line_n = PARITY_ODD ? ~parity_acc : parity_acc;
                if (bit_end) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                line_n = 1'b1;
                if (bit_end && (bit_cnt == STOP_LAST)) begin
                    done_n = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        count_n = count;
        if (wr_ok && !pop) begin
            count_n = count + CNT_W'(1);
        end else if (!wr_ok && pop) begin
            count_n = count - CNT_W'(1);
        end
    end

    // FIFO storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            fifo_full     <= 1'b0;
            fifo_empty    <= 1'b1;
            overflow_flag <= 1'b0;
            busy_flag     <= 1'b0;
            tx_done       <= 1'b0;
            data_out      <= 1'b1;
            shreg         <= '0;
            parity_acc    <= 1'b0;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
        end else begin
            state <= state_n;
            count <= count_n;

            // data_out and tx_done lag the state by one cycle, so the pulse
            // coincides with the last stop-bit cycle as seen on the line.
            data_out <= line_n;
            tx_done  <= done_n;

            fifo_full  <= (count_n == CNT_FULL);
            fifo_empty <= (count_n == '0);
            busy_flag  <= (state_n != IDLE) || (count_n != '0);

            if (write_strobe && !wr_ok) begin
                overflow_flag <= 1'b1;
            end
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            if ((state == IDLE) || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            // bit_cnt indexes data bits in DATA and stop bits in STOP.
            if (bit_end && (state == DATA)) begin
                bit_cnt <= (bit_cnt == DATA_LAST) ? 3'd0 : bit_cnt + 3'd1;
            end else if (bit_end && (state == STOP)) begin
                bit_cnt <= (bit_cnt == STOP_LAST) ? 3'd0 : bit_cnt + 3'd1;
            end

            if (pop) begin
                shreg      <= mem[rd_ptr];
                parity_acc <= 1'b0;
            end else if (bit_end && (state == DATA)) begin
                shreg      <= {1'b0, shreg[DATA_BITS-1:1]};
                parity_acc <= parity_acc ^ shreg[0];
            end
        end
    end

endmodule
